// File: rtl/vliw_core_if.sv
// Memory bus between the vliw_core CPU (master) and the shared ram (slave).
// Read data is combinational from the address driven in the same cycle.
interface vliw_core_if;
    logic [55:0] addressBus;
    logic [63:0] dataIn;
    logic [63:0] dataOut;
    logic        enableWrite;

    modport master (
        output addressBus,
        output dataOut,
        output enableWrite,
        input  dataIn
    );

    modport slave (
        input  addressBus,
        input  dataOut,
        input  enableWrite,
        output dataIn
    );
endinterface

// File: rtl/vliw_core.sv
// Two-slot 64-bit VLIW core, multi-cycle FETCH/EXEC/MEM/HALT sequencing.
// Define VLIW_MUL_EN to turn opcode 14 into a 64-bit MUL in either slot.
module vliw_core (
    input  logic        clk,
    input  logic        rst,
    vliw_core_if.master mem
);
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_XOR  = 6'd5;
    localparam logic [5:0] OP_SHL  = 6'd6;
    localparam logic [5:0] OP_SHR  = 6'd7;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LD   = 6'd9;
    localparam logic [5:0] OP_ST   = 6'd10;
    localparam logic [5:0] OP_BEQ  = 6'd11;
    localparam logic [5:0] OP_HALT = 6'd12;
`ifdef VLIW_MUL_EN
    localparam logic [5:0] OP_MUL  = 6'd14;
`endif

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t      state_q;
    logic [55:0] pc_q;
    logic [63:0] rf_q [16];
    logic [63:0] ir_q;
    logic [55:0] ea_q;
    logic [63:0] sd_q;

    logic [5:0]  op0, op1;
    logic [3:0]  rd0, rd1;
    logic [63:0] a0, b0, a1, b1, imm0, imm1;
    logic [64:0] res0, res1;
    logic [55:0] ea_d, pc_d;
    logic        taken;

    // Result bit 64 is the write enable; LD/ST/BEQ/HALT fall to default, so
    // they are NOPs in slot0 and leave no ALU write in slot1.
    function automatic logic [64:0] alu(input logic [5:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input logic [63:0] imm);
        logic [64:0] r;
        case (op)
            OP_ADD:  r = {1'b1, a + b};
            OP_SUB:  r = {1'b1, a - b};
            OP_AND:  r = {1'b1, a & b};
            OP_OR:   r = {1'b1, a | b};
            OP_XOR:  r = {1'b1, a ^ b};
            OP_SHL:  r = {1'b1, a << b[5:0]};
            OP_SHR:  r = {1'b1, a >> b[5:0]};
            OP_ADDI: r = {1'b1, a + imm};
`ifdef VLIW_MUL_EN
            OP_MUL:  r = {1'b1, a * b};
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    assign op0  = ir_q[31:26];
    assign rd0  = ir_q[25:22];
    assign a0   = rf_q[ir_q[21:18]];
    assign b0   = rf_q[ir_q[17:14]];
    assign imm0 = {{50{ir_q[13]}}, ir_q[13:0]};
    assign op1  = ir_q[63:58];
    assign rd1  = ir_q[57:54];
    assign a1   = rf_q[ir_q[53:50]];
    assign b1   = rf_q[ir_q[49:46]];
    assign imm1 = {{50{ir_q[45]}}, ir_q[45:32]};

    assign res0  = alu(op0, a0, b0, imm0);
    assign res1  = alu(op1, a1, b1, imm1);
    assign ea_d  = (a1[55:0] + imm1[55:0]) & ~56'h7;
    assign taken = (op1 == OP_BEQ) && (a1 == b1);
    assign pc_d  = taken ? pc_q + 56'd8 + {imm1[52:0], 3'b000} : pc_q + 56'd8;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            ea_q    <= '0;
            sd_q    <= '0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_q    <= mem.dataIn;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    // slot1 is written last so it wins on a shared rd
                    if (res0[64] && rd0 != 4'd0) rf_q[rd0] <= res0[63:0];
                    if (res1[64] && rd1 != 4'd0) rf_q[rd1] <= res1[63:0];
                    pc_q <= pc_d;
                    if (op1 == OP_LD || op1 == OP_ST) begin
                        ea_q    <= ea_d;
                        sd_q    <= b1;
                        state_q <= S_MEM;
                    end else if (op1 == OP_HALT) begin
                        state_q <= S_HALT;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (op1 == OP_LD && rd1 != 4'd0) rf_q[rd1] <= mem.dataIn;
                    state_q <= S_FETCH;
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    // rst gates the bus directly so a store caught mid-MEM never commits.
    assign mem.enableWrite = !rst && (state_q == S_MEM) && (op1 == OP_ST);
    assign mem.dataOut     = mem.enableWrite ? sd_q : '0;
    assign mem.addressBus  = rst                  ? '0   :
                             (state_q == S_FETCH) ? pc_q :
                             (state_q == S_MEM)   ? ea_q : '0;
endmodule

// File: tb/tb_vliw_core.sv
// Directed bench for vliw_core: program loaded under reset, stores checked
// against a queue of expected writes, fetch addresses checked at known cycles.
module tb_vliw_core;
    localparam logic [5:0] NOP  = 6'd0;
    localparam logic [5:0] ADD  = 6'd1;
    localparam logic [5:0] SUB  = 6'd2;
    localparam logic [5:0] ANDo = 6'd3;
    localparam logic [5:0] ORo  = 6'd4;
    localparam logic [5:0] XORo = 6'd5;
    localparam logic [5:0] SHL  = 6'd6;
    localparam logic [5:0] SHR  = 6'd7;
    localparam logic [5:0] ADDI = 6'd8;
    localparam logic [5:0] LD   = 6'd9;
    localparam logic [5:0] ST   = 6'd10;
    localparam logic [5:0] BEQ  = 6'd11;
    localparam logic [5:0] HALT = 6'd12;
    localparam logic [5:0] MUL  = 6'd14;

    typedef struct {
        logic [55:0] a;
        logic [63:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [7:0]  ld_idx;
    logic [63:0] ld_data;
    logic [63:0] ram [0:255];
    int          total = 0;
    int          passed = 0;
    int          cur = 0;
    wr_t         exp_q[$];

    vliw_core_if bus ();
    vliw_core dut (.clk(clk), .rst(rst), .mem(bus));

    always #5 clk = ~clk;

    assign bus.dataIn = ram[8'(bus.addressBus >> 3)];

    always @(posedge clk) begin
        if (ld_en) ram[ld_idx] <= ld_data;
        else if (bus.enableWrite) ram[8'(bus.addressBus >> 3)] <= bus.dataOut;
    end

    function automatic logic [31:0] syl(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [13:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic load(input logic [7:0] idx, input logic [63:0] d);
        ld_en   = 1'b1;
        ld_idx  = idx;
        ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic push(input logic [55:0] a, input logic [63:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int k);
        while (cur < k) begin
            @(negedge clk);
            cur++;
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus.enableWrite === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) passed++;
            else $error("FAIL write_unexpected observed addr=0x%0h data=0x%0h expected no write",
                        bus.addressBus, bus.dataOut);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_addr", 64'(bus.addressBus), 64'(e.a));
                chk("write_data", bus.dataOut, e.d);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        ld_en   = 1'b0;
        ld_idx  = '0;
        ld_data = '0;

        load(8'd0,  {syl(ADDI, 4'd2, 4'd0, 4'd0, 14'd7),     syl(ADDI, 4'd1, 4'd0, 4'd0, 14'd5)});
        load(8'd1,  {syl(SUB,  4'd4, 4'd2, 4'd1, 14'd0),     syl(ADD,  4'd3, 4'd1, 4'd2, 14'd0)});
        load(8'd2,  {syl(ADD,  4'd2, 4'd1, 4'd0, 14'd0),     syl(ADD,  4'd1, 4'd2, 4'd0, 14'd0)});
        load(8'd3,  {syl(ST,   4'd0, 4'd0, 4'd3, 14'h100),   32'h0});
        load(8'd4,  {syl(LD,   4'd5, 4'd0, 4'd0, 14'h100),   32'h0});
        load(8'd5,  {syl(ST,   4'd0, 4'd0, 4'd5, 14'h108),   32'h0});
        load(8'd6,  {syl(ST,   4'd0, 4'd0, 4'd1, 14'h113),   32'h0});
        load(8'd7,  {syl(ST,   4'd0, 4'd0, 4'd2, 14'h118),   32'h0});
        load(8'd8,  {syl(ST,   4'd0, 4'd0, 4'd4, 14'h120),   32'h0});
        load(8'd9,  {syl(ADDI, 4'd7, 4'd0, 4'd0, 14'd99),    syl(ADDI, 4'd8, 4'd0, 4'd0, 14'd6)});
        load(8'd10, {syl(NOP,  4'd0, 4'd0, 4'd0, 14'd0),     syl(MUL,  4'd7, 4'd8, 4'd1, 14'd0)});
        load(8'd11, {syl(ST,   4'd0, 4'd0, 4'd7, 14'h128),   32'h0});
        load(8'd12, {syl(ADDI, 4'd10, 4'd0, 4'd0, 14'd2),    syl(ADDI, 4'd10, 4'd0, 4'd0, 14'd1)});
        load(8'd13, {syl(ST,   4'd0, 4'd0, 4'd10, 14'h130),  32'h0});
        load(8'd14, {32'h0,                                  syl(ST,   4'd0, 4'd0, 4'd3, 14'h1F0)});
        load(8'd15, {syl(SHR,  4'd12, 4'd3, 4'd4, 14'd0),    syl(SHL,  4'd11, 4'd3, 4'd4, 14'd0)});
        load(8'd16, {syl(ST,   4'd0, 4'd0, 4'd11, 14'h138),  syl(XORo, 4'd13, 4'd11, 4'd12, 14'd0)});
        load(8'd17, {syl(ST,   4'd0, 4'd0, 4'd13, 14'h140),  syl(ORo,  4'd14, 4'd11, 4'd3, 14'd0)});
        load(8'd18, {syl(ST,   4'd0, 4'd0, 4'd14, 14'h148),  syl(ANDo, 4'd15, 4'd13, 4'd1, 14'd0)});
        load(8'd19, {syl(ST,   4'd0, 4'd0, 4'd15, 14'h150),  syl(HALT, 4'd0, 4'd0, 4'd0, 14'd0)});
        load(8'd20, {syl(BEQ,  4'd0, 4'd1, 4'd2, 14'd5),     32'h0});
        load(8'd21, {syl(BEQ,  4'd0, 4'd0, 4'd0, 14'd1),     32'h0});
        load(8'd22, {syl(ST,   4'd0, 4'd0, 4'd3, 14'h158),   32'h0});
        load(8'd23, {syl(HALT, 4'd0, 4'd0, 4'd0, 14'd0),     32'h0});

        push(56'h100, 64'd12);
        push(56'h108, 64'd12);
        push(56'h110, 64'd7);
        push(56'h118, 64'd5);
        push(56'h120, 64'd2);
`ifdef VLIW_MUL_EN
        push(56'h128, 64'd42);
`else
        push(56'h128, 64'd99);
`endif
        push(56'h130, 64'd2);
        push(56'h138, 64'd48);
        push(56'h140, 64'd51);
        push(56'h148, 64'd60);
        push(56'h150, 64'd3);

        repeat (3) begin
            @(negedge clk);
            chk("rst_addr", 64'(bus.addressBus), 64'h0);
            chk("rst_we",   64'(bus.enableWrite), 64'h0);
            chk("rst_dout", bus.dataOut, 64'h0);
        end

        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cur = 0;
        chk("fetch0_addr", 64'(bus.addressBus), 64'h0);
        goto(1);
        chk("exec_addr_idle", 64'(bus.addressBus), 64'h0);
        goto(2);
        chk("fetch1_addr", 64'(bus.addressBus), 64'h8);
        goto(8);
        chk("st_addr", 64'(bus.addressBus), 64'h100);
        chk("st_we",   64'(bus.enableWrite), 64'h1);
        chk("st_dout", bus.dataOut, 64'd12);
        goto(9);
        chk("after_st_fetch", 64'(bus.addressBus), 64'h20);
        goto(11);
        chk("ld_addr", 64'(bus.addressBus), 64'h100);
        chk("ld_we",   64'(bus.enableWrite), 64'h0);
        chk("ld_dout", bus.dataOut, 64'h0);
        goto(17);
        chk("unaligned_addr", 64'(bus.addressBus), 64'h110);
        goto(52);
        chk("beq_ne_fetch", 64'(bus.addressBus), 64'hA0);
        goto(54);
        chk("beq_ne_next", 64'(bus.addressBus), 64'hA8);
        goto(56);
        chk("beq_taken_next", 64'(bus.addressBus), 64'hB8);

        for (int i = 0; i < 100; i++) begin
            goto(cur + 1);
            chk("halt_addr", 64'(bus.addressBus), 64'h0);
            chk("halt_we",   64'(bus.enableWrite), 64'h0);
        end
        chk("sb_drain1", 64'(exp_q.size()), 64'd0);

        @(posedge clk);
        #1 rst = 1'b1;
        load(8'd0, {32'h0,                                syl(ADDI, 4'd1, 4'd0, 4'd0, 14'h55)});
        load(8'd1, {syl(ST,  4'd0, 4'd0, 4'd1, 14'h200),  32'h0});
        load(8'd2, {syl(BEQ, 4'd0, 4'd1, 4'd1, 14'h3FFF), 32'h0});
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cur = 0;
        chk("p2_fetch0", 64'(bus.addressBus), 64'h0);
        goto(3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midmem_rst_we",   64'(bus.enableWrite), 64'h0);
        chk("midmem_rst_addr", 64'(bus.addressBus), 64'h0);
        chk("midmem_rst_dout", bus.dataOut, 64'h0);

        push(56'h200, 64'h55);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cur = 0;
        chk("restart_pc", 64'(bus.addressBus), 64'h0);
        goto(4);
        chk("p2_st_addr", 64'(bus.addressBus), 64'h200);
        chk("p2_st_we",   64'(bus.enableWrite), 64'h1);
        goto(5);
        chk("loop_fetch_a", 64'(bus.addressBus), 64'h10);
        goto(7);
        chk("loop_fetch_b", 64'(bus.addressBus), 64'h10);
        goto(9);
        chk("loop_fetch_c", 64'(bus.addressBus), 64'h10);
        chk("sb_drain2", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
